// File: rtl/placement_request_sequencer.sv
// Host-side request sequencer for the placement pipeline: request FIFO, credit-gated issue,
// latency-matched tracking and response FIFO. Optional perf counters: SEQ_PERF_CNT_EN.
package placement_request_sequencer_pkg;
    localparam int unsigned DIM_W    = 5;
    localparam int unsigned XY_W     = 8;
    localparam int unsigned STRIKE_W = 4;

    typedef struct packed {
        logic [DIM_W-1:0] width;
        logic [DIM_W-1:0] height;
    } req_t;

    typedef struct packed {
        logic [XY_W-1:0]     x;
        logic [XY_W-1:0]     y;
        logic [STRIKE_W-1:0] strike;
        req_t                req;
    } rsp_t;
endpackage

module placement_request_sequencer
    import placement_request_sequencer_pkg::*;
#(
    parameter int unsigned PLACER_LATENCY = 8,
    parameter int unsigned REQ_DEPTH      = 8,
    parameter int unsigned RSP_DEPTH      = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [DIM_W-1:0]    req_width_i,
    input  logic [DIM_W-1:0]    req_height_i,
    output logic [DIM_W-1:0]    placer_width_o,
    output logic [DIM_W-1:0]    placer_height_o,
    input  logic [XY_W-1:0]     placer_x_i,
    input  logic [XY_W-1:0]     placer_y_i,
    input  logic [STRIKE_W-1:0] placer_strike_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [XY_W-1:0]     rsp_x_o,
    output logic [XY_W-1:0]     rsp_y_o,
    output logic [STRIKE_W-1:0] rsp_strike_o,
    output logic [DIM_W-1:0]    rsp_width_o,
    output logic [DIM_W-1:0]    rsp_height_o,
    output logic                busy_o,
    output logic [15:0]         perf_issued_o,
    output logic [15:0]         perf_stall_o
);
    // One stage for the issue register plus PLACER_LATENCY stages inside the placer.
    localparam int unsigned SR_LEN = PLACER_LATENCY + 1;
    localparam int unsigned REQ_AW = $clog2(REQ_DEPTH);
    localparam int unsigned RSP_AW = $clog2(RSP_DEPTH);
    localparam int unsigned INF_W  = $clog2(SR_LEN + 1);
    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + SR_LEN + 1) + 1;

    req_t              req_mem [REQ_DEPTH];
    logic [REQ_AW:0]   req_wr_q;
    logic [REQ_AW:0]   req_rd_q;
    rsp_t              rsp_mem [RSP_DEPTH];
    logic [RSP_AW:0]   rsp_wr_q;
    logic [RSP_AW:0]   rsp_rd_q;
    logic [SR_LEN-1:0] sr_q;
    req_t              echo_q [SR_LEN];

    logic            req_empty;
    logic            req_full;
    logic            req_push;
    logic            issue;
    logic            has_credit;
    logic            capture;
    logic            rsp_empty;
    logic            rsp_pop;
    logic [RSP_AW:0] rsp_count;
    logic [INF_W-1:0] inflight;
    rsp_t            rsp_head;

    assign req_empty = (req_wr_q == req_rd_q);
    assign req_full  = (req_wr_q[REQ_AW] != req_rd_q[REQ_AW]) &&
                       (req_wr_q[REQ_AW-1:0] == req_rd_q[REQ_AW-1:0]);
    assign req_push  = req_valid_i && !req_full;

    // Credits reserve a response slot for every request still travelling through the placer.
    assign rsp_count  = rsp_wr_q - rsp_rd_q;
    assign inflight   = INF_W'($countones(sr_q));
    assign has_credit = (CNT_W'(rsp_count) + CNT_W'(inflight)) < CNT_W'(RSP_DEPTH);
    assign issue      = !req_empty && has_credit;

    assign capture   = sr_q[SR_LEN-1];
    assign rsp_empty = (rsp_wr_q == rsp_rd_q);
    assign rsp_pop   = !rsp_empty && rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (req_push) req_mem[req_wr_q[REQ_AW-1:0]] <= '{width: req_width_i, height: req_height_i};
    end

    always_ff @(posedge clk_i) begin
        if (capture) rsp_mem[rsp_wr_q[RSP_AW-1:0]] <= '{x: placer_x_i, y: placer_y_i,
                                                        strike: placer_strike_i,
                                                        req: echo_q[SR_LEN-1]};
    end

    // Pointers, in-flight tracking and the issue register (echo_q[0] feeds the placer).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_wr_q <= '0;
            req_rd_q <= '0;
            rsp_wr_q <= '0;
            rsp_rd_q <= '0;
            sr_q     <= '0;
            for (int i = 0; i < int'(SR_LEN); i++) echo_q[i] <= '0;
        end else begin
            if (req_push) req_wr_q <= req_wr_q + (REQ_AW+1)'(1);
            if (issue)    req_rd_q <= req_rd_q + (REQ_AW+1)'(1);
            if (capture)  rsp_wr_q <= rsp_wr_q + (RSP_AW+1)'(1);
            if (rsp_pop)  rsp_rd_q <= rsp_rd_q + (RSP_AW+1)'(1);
            sr_q      <= {sr_q[SR_LEN-2:0], issue};
            echo_q[0] <= issue ? req_mem[req_rd_q[REQ_AW-1:0]] : '0;
            for (int i = 1; i < int'(SR_LEN); i++) echo_q[i] <= echo_q[i-1];
        end
    end

    assign rsp_head = rsp_empty ? '0 : rsp_mem[rsp_rd_q[RSP_AW-1:0]];

    assign req_ready_o     = !req_full;
    assign placer_width_o  = echo_q[0].width;
    assign placer_height_o = echo_q[0].height;
    assign rsp_valid_o     = !rsp_empty;
    assign rsp_x_o         = rsp_head.x;
    assign rsp_y_o         = rsp_head.y;
    assign rsp_strike_o    = rsp_head.strike;
    assign rsp_width_o     = rsp_head.req.width;
    assign rsp_height_o    = rsp_head.req.height;
    assign busy_o          = !req_empty || (|sr_q) || !rsp_empty;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_issued_q;
    logic [15:0] perf_stall_q;

    // Saturating counters of issues and of credit-starved cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (issue && (perf_issued_q != 16'hFFFF))
                perf_issued_q <= perf_issued_q + 16'd1;
            if (!req_empty && !has_credit && (perf_stall_q != 16'hFFFF))
                perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`else
    assign perf_issued_o = 16'h0000;
    assign perf_stall_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_placement_request_sequencer.sv
// Randomized bench for placement_request_sequencer: a behavioural placer plus a queue-based
// reference of request/response flow, compared every cycle.
module tb_placement_request_sequencer;
    localparam int L     = 8;
    localparam int QD    = 8;
    localparam int RD    = 8;
    localparam int STRIP = 64;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] s;
    } pres_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_width = '0;
    logic [4:0]  req_height = '0;
    logic [4:0]  placer_width;
    logic [4:0]  placer_height;
    logic [7:0]  placer_x;
    logic [7:0]  placer_y;
    logic [3:0]  placer_strike;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_x;
    logic [7:0]  rsp_y;
    logic [3:0]  rsp_strike;
    logic [4:0]  rsp_width;
    logic [4:0]  rsp_height;
    logic        busy;
    logic [15:0] perf_issued;
    logic [15:0] perf_stall;

    int n_chk = 0;
    int n_err = 0;

    placement_request_sequencer #(.PLACER_LATENCY(L), .REQ_DEPTH(QD), .RSP_DEPTH(RD)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_width_i(req_width), .req_height_i(req_height),
        .placer_width_o(placer_width), .placer_height_o(placer_height),
        .placer_x_i(placer_x), .placer_y_i(placer_y), .placer_strike_i(placer_strike),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_x_o(rsp_x), .rsp_y_o(rsp_y), .rsp_strike_o(rsp_strike),
        .rsp_width_o(rsp_width), .rsp_height_o(rsp_height),
        .busy_o(busy), .perf_issued_o(perf_issued), .perf_stall_o(perf_stall)
    );

    always #5 clk = ~clk;

    // Strip packer: a rectangle that does not fit on the current row strikes and starts a new row.
    function automatic pres_t place_res(input pres_t st, input logic [4:0] w);
        pres_t r = st;
        if (int'(st.x) + int'(w) > STRIP) begin
            r.x = 8'd0;
            r.y = st.y + 8'd8;
            r.s = st.s + 4'd1;
        end
        return r;
    endfunction

    function automatic pres_t place_nxt(input pres_t st, input logic [4:0] w);
        pres_t r = place_res(st, w);
        r.x = r.x + 8'(w);
        return r;
    endfunction

    // Behavioural placer: samples its inputs each edge, result visible L edges later.
    pres_t pipe [L];
    pres_t pl_st;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
            pl_st <= '0;
        end else begin
            if (placer_width != 5'd0) begin
                pipe[0] <= place_res(pl_st, placer_width);
                pl_st   <= place_nxt(pl_st, placer_width);
            end else begin
                pipe[0] <= 20'($urandom);
            end
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign placer_x      = pipe[L-1].x;
    assign placer_y      = pipe[L-1].y;
    assign placer_strike = pipe[L-1].s;

    // Reference model state
    logic [9:0]  m_reqq [$];
    logic [29:0] m_fly  [$];
    int          m_flyt [$];
    logic [29:0] m_rspq [$];
    pres_t       m_pl;
    logic [4:0]  m_pw, m_ph;
    int          m_iss, m_stall, cyc, d_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_reqq.delete(); m_fly.delete(); m_flyt.delete(); m_rspq.delete();
        m_pl = '0; m_pw = '0; m_ph = '0; m_iss = 0; m_stall = 0; d_acc = 0;
    endtask

    task automatic step(input logic v, input logic [4:0] w, input logic [4:0] h, input logic rr);
        int nreq, nfly, nrsp;
        logic push, iss, cap, pop;
        logic [9:0] d;
        pres_t r;
        @(negedge clk);
        nreq = m_reqq.size(); nfly = m_fly.size(); nrsp = m_rspq.size();
        chk("req_ready", req_ready, nreq < QD);
        chk("rsp_valid", rsp_valid, nrsp > 0);
        if (nrsp > 0) chk("rsp_data", {rsp_x, rsp_y, rsp_strike, rsp_width, rsp_height}, m_rspq[0]);
        chk("placer_in", {placer_width, placer_height}, {m_pw, m_ph});
        chk("busy", busy, (nreq > 0) || (nfly > 0) || (nrsp > 0));
`ifdef SEQ_PERF_CNT_EN
        chk("perf_issued", perf_issued, m_iss);
        chk("perf_stall", perf_stall, m_stall);
`else
        chk("perf_off", {perf_issued, perf_stall}, 0);
`endif
        if (v && req_ready) d_acc++;
        req_valid = v; req_width = w; req_height = h; rsp_ready = rr;

        push = v && (nreq < QD);
        iss  = (nreq > 0) && (RD - nrsp - nfly > 0);
        cap  = (nfly > 0) && (m_flyt[0] == cyc - (L + 1));
        pop  = rr && (nrsp > 0);
        if (pop) void'(m_rspq.pop_front());
        if (cap) begin
            m_rspq.push_back(m_fly.pop_front());
            void'(m_flyt.pop_front());
        end
        if (iss) begin
            d = m_reqq.pop_front();
            r = place_res(m_pl, d[9:5]);
            m_pl = place_nxt(m_pl, d[9:5]);
            m_fly.push_back({r, d});
            m_flyt.push_back(cyc);
            {m_pw, m_ph} = d;
            if (m_iss < 65535) m_iss++;
        end else begin
            {m_pw, m_ph} = '0;
        end
        if ((nreq > 0) && !iss && (m_stall < 65535)) m_stall++;
        if (push) m_reqq.push_back({w, h});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 0; rsp_ready = 0; req_width = '0; req_height = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_zero", {placer_width, placer_height, rsp_valid, rsp_x, rsp_y, rsp_strike,
                         rsp_width, rsp_height, busy, perf_issued, perf_stall}, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rdim();
        return 5'($urandom_range(1, 31));
    endfunction

    initial begin
        int lat;
        cyc = 0;
        model_clear();
        do_reset();

        // Single request latency
        step(1'b1, 5'd4, 5'd4, 1'b1);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step(1'b0, '0, '0, 1'b1);
            lat++;
        end
        chk("latency", lat, 10);
        chk("single_wh", {rsp_width, rsp_height}, {5'd4, 5'd4});
        repeat (3) step(1'b0, '0, '0, 1'b1);

        // Back-to-back burst of 8
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, rdim(), rdim(), 1'b1);
        repeat (16) step(1'b0, '0, '0, 1'b1);
`ifdef SEQ_PERF_CNT_EN
        chk("burst_issued", perf_issued, 16'd8);
        chk("burst_stall", perf_stall, 16'd0);
`endif

        // Credit exhaustion with host not accepting, then request FIFO full
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, rdim(), rdim(), 1'b0);
        chk("req_full", req_ready, 1'b0);
        chk("accepted", d_acc, 16);
`ifdef SEQ_PERF_CNT_EN
        chk("credit_issued", perf_issued, 16'd8);
        chk("stall_seen", perf_stall != 16'd0, 1'b1);
`endif
        repeat (40) step(1'b0, '0, '0, 1'b1);
        chk("drained", busy, 1'b0);

        // Reset with requests in flight
        for (int i = 0; i < 3; i++) step(1'b1, rdim(), rdim(), 1'b1);
        repeat (2) step(1'b0, '0, '0, 1'b1);
        do_reset();
        repeat (20) step(1'b0, '0, '0, 1'b1);

        // Random traffic with varying host backpressure
        for (int i = 0; i < 3000; i++) begin
            if ((i / 200) % 3 == 1)
                step(1'($urandom % 4 != 0), rdim(), rdim(), 1'($urandom % 4 == 0));
            else
                step(1'($urandom % 3 != 0), rdim(), rdim(), 1'($urandom % 5 != 0));
        end
        repeat (40) step(1'b0, '0, '0, 1'b1);
        chk("final_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
